// File: rtl/stripe_tx_sched.sv
// stripe_tx_sched: transmit-side scheduler for the byte-striping datapath.
// Collects a serial byte stream (valid/ready) into a word of 1, 2 or 4 bytes,
// one byte per active lane. It issues that word to the four lanes as a single
// handshaked transfer. Handles end-of-packet padding and lane-count
// configuration, and counts transmitted words.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_lanes    lane-count request (00=1, 01=2, 10=4, 11=illegal -> 4)
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_last      last byte of packet (qualified by in_valid)
//   in_ready     byte accepted this cycle
//   out_valid    assembled word valid
//   out_data     lane0=[7:0] .. lane3=[31:24]
//   out_lane_en  per-lane enable of the current word
//   out_ready    lanes accept the word
//   word_count   transferred words, wraps
//   cfg_err      sticky illegal-configuration flag
module stripe_tx_sched #(
  parameter logic [7:0] PAD_BYTE = 8'hBC,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cfg_lanes,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [3:0]       out_lane_en,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             cfg_err
);

  typedef enum logic {FILL, SEND} state_t;

  state_t      state, state_nx;
  logic        started;
  logic [1:0]  idx, idx_nx;
  logic [1:0]  lanes, lanes_nx;     // latched lane code: 0=1, 1=2, 2=4 lanes
  logic        err_nx;
  logic [31:0] word, word_nx;
  logic [1:0]  lim;
  logic        acc;

  // Index of the highest active lane for a lane code.
  function automatic logic [1:0] last_lane(input logic [1:0] code);
    case (code)
      2'b00:   last_lane = 2'd0;
      2'b01:   last_lane = 2'd1;
      default: last_lane = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] code);
    case (code)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign lim = last_lane(lanes);

  // in_ready is held low until the first edge after reset release.
  assign in_ready    = (state == FILL) && started;
  assign acc         = in_valid && in_ready;
  assign out_valid   = (state == SEND);
  assign out_data    = (state == SEND) ? word : 32'h0;
  assign out_lane_en = (state == SEND) ? lane_mask(lanes) : 4'b0000;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    lanes_nx = lanes;
    err_nx   = cfg_err;
    word_nx  = word;
    case (state)
      FILL: begin
        if (acc) begin
          // First byte of a word clears the buffer so inactive lanes carry 00.
          if (idx == 2'd0) word_nx = 32'h0;
          word_nx[{idx, 3'b000} +: 8] = in_data;
          if ((idx == lim) || in_last) begin
            state_nx = SEND;
            idx_nx   = 2'd0;
            if (in_last) begin
              for (int i = 1; i < 4; i++) begin
                if ((i > int'(idx)) && (i <= int'(lim))) word_nx[i*8 +: 8] = PAD_BYTE;
              end
            end
          end else begin
            idx_nx = idx + 2'd1;
          end
        end else if (idx == 2'd0) begin
          // Word boundary with no byte arriving: take the new lane count.
          if (cfg_lanes == 2'b11) begin
            lanes_nx = 2'b10;
            err_nx   = 1'b1;
          end else begin
            lanes_nx = cfg_lanes;
          end
        end
      end
      SEND: begin
        if (out_ready) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      started    <= 1'b0;
      idx        <= 2'd0;
      lanes      <= 2'b00;
      cfg_err    <= 1'b0;
      word_count <= '0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      idx     <= idx_nx;
      lanes   <= lanes_nx;
      cfg_err <= err_nx;
      if (out_valid && out_ready) word_count <= word_count + 1'b1;
    end
  end

  // Word buffer is data only; it is masked on out_data outside SEND.
  always_ff @(posedge clk) begin
    word <= word_nx;
  end

endmodule

// File: tb/tb_stripe_tx_sched.sv
module tb_stripe_tx_sched;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       cfg_lanes;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [3:0]       out_lane_en;
  logic             out_ready;
  logic [CNT_W-1:0] word_count;
  logic             cfg_err;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_wc = 0;

  stripe_tx_sched #(.PAD_BYTE(8'hBC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_lanes(cfg_lanes),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane_en(out_lane_en),
    .out_ready(out_ready), .word_count(word_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offer one byte; returns 1 ns after the edge that accepted it.
  task automatic put(input logic [7:0] d, input logic last);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("put_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called right after the completing byte; out_ready must be high.
  task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] en);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_en"}, 32'(out_lane_en), 32'(en));
    chk({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    exp_wc = (exp_wc + 1) % 16;
    chk({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
    chk({tag, "_vld_lo"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; cfg_lanes = 2'b10; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_en", 32'(out_lane_en), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_rdy_lo", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_rdy_hi", 32'(in_ready), 32'd1);

    // 4 lanes, two full words
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0);
    chk("w1_not_yet", 32'(out_valid), 32'd0);
    put(8'h04, 0);
    expect_word("w1", 32'h04030201, 4'b1111);
    put(8'h05, 0); put(8'h06, 0); put(8'h07, 0); put(8'h08, 0);
    expect_word("w2", 32'h08070605, 4'b1111);

    // early last with padding, next byte in lane0
    put(8'hAA, 0); put(8'hBB, 1);
    expect_word("pad4", 32'hBCBCBBAA, 4'b1111);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0);
    expect_word("after_pad", 32'h44332211, 4'b1111);

    // 2 lanes, then 1 lane
    cfg_lanes = 2'b01; idle();
    put(8'h10, 0); put(8'h20, 0);
    expect_word("l2a", 32'h00002010, 4'b0011);
    put(8'h30, 1);
    expect_word("l2pad", 32'h0000BC30, 4'b0011);
    cfg_lanes = 2'b00; idle();
    put(8'h5A, 0);
    expect_word("l1", 32'h0000005A, 4'b0001);

    // backpressure in SEND
    cfg_lanes = 2'b10; idle();
    out_ready = 1'b0;
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h99;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_data", out_data, 32'h04030201);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_wc = (exp_wc + 1) % 16;
    chk("bp_wc", 32'(word_count), 32'(exp_wc));
    chk("bp_vld_lo", 32'(out_valid), 32'd0);
    chk("bp_rdy_hi", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    put(8'h98, 0); put(8'h97, 0); put(8'h96, 0);
    expect_word("bp_held", 32'h96979899, 4'b1111);

    // lane count change mid-word is deferred; in_last without in_valid ignored
    put(8'h01, 0); put(8'h02, 0);
    cfg_lanes = 2'b01;
    put(8'h03, 0); put(8'h04, 0);
    expect_word("cfg_defer", 32'h04030201, 4'b1111);
    @(negedge clk); in_last = 1'b1; idle(); in_last = 1'b0;
    put(8'h05, 0); put(8'h06, 0);
    expect_word("cfg_new2", 32'h00000605, 4'b0011);
    cfg_lanes = 2'b11; idle();
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    put(8'h0A, 0); put(8'h0B, 0); put(8'h0C, 0); put(8'h0D, 0);
    expect_word("cfg_ill4", 32'h0D0C0B0A, 4'b1111);
    cfg_lanes = 2'b10; idle();
    chk("cfg_err_sticky", 32'(cfg_err), 32'd1);

    // run word_count through its wrap
    while (exp_wc != 0) begin
      put(8'hC1, 0); put(8'hC2, 0); put(8'hC3, 0); put(8'hC4, 0);
      expect_word("wrap", 32'hC4C3C2C1, 4'b1111);
    end
    chk("wrap_zero", 32'(word_count), 32'd0);

    // asynchronous reset while in SEND
    put(8'h01, 0); put(8'h02, 0);
    cfg_lanes = 2'b00;
    out_ready = 1'b0;
    put(8'h03, 0); put(8'h04, 0);
    chk("ar_pre_vld", 32'(out_valid), 32'd1);
    #2 reset = 1'b0; #1;
    chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_en", 32'(out_lane_en), 32'd0);
    chk("ar_wc", 32'(word_count), 32'd0);
    chk("ar_err", 32'(cfg_err), 32'd0);
    exp_wc = 0;
    @(negedge clk); reset = 1'b1; out_ready = 1'b1; cfg_lanes = 2'b10;
    put(8'hE1, 0); put(8'hE2, 0); put(8'hE3, 0); put(8'hE4, 0);
    expect_word("ar_after", 32'hE4E3E2E1, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
